id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised instruction-decode stage with an integrated ID/EX pipeline register. It decodes logic, immediate and shift instructions, forwards operands from the EX and MEM stages, and detects load-use hazards. It sits between the IF/ID register and the EX stage and replaces the purely combinational decoder-plus-separate-pipeline-register arrangement.

Parameters:
DATA_W, 32, operand/register data width
INST_W, 32, instruction width
PC_W, 32, program counter width
REG_AW, 5, register-file address width
FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = regfile data only, and every RAW hit on EX/MEM write stalls

Ports:
clk  in  1  stage clock
rst  in  1  synchronous active-high reset
pc_i  in  PC_W  PC of instruction in ID
inst_i  in  INST_W  instruction in ID
inst_valid_i  in  1  ID slot holds a real instruction
reg1_data_i  in  DATA_W  regfile read data, port 1
reg2_data_i  in  DATA_W  regfile read data, port 2
reg1_read_o  out  1  regfile port-1 read enable (combinational)
reg2_read_o  out  1  regfile port-2 read enable (combinational)
reg1_addr_o  out  REG_AW  inst_i[25:21] (combinational)
reg2_addr_o  out  REG_AW  inst_i[20:16] (combinational)
ex_wreg_i  in  1  EX-stage instruction writes a register
ex_wd_i  in  REG_AW  EX destination
ex_wdata_i  in  DATA_W  EX result
ex_is_load_i  in  1  EX instruction is a load; result not yet available
mem_wreg_i  in  1  MEM-stage write enable
mem_wd_i  in  REG_AW  MEM destination
mem_wdata_i  in  DATA_W  MEM result
stall_i  in  1  downstream stall; hold ID/EX register
flush_i  in  1  squash; load bubble into ID/EX register
stallreq_o  out  1  hazard stall request to controller (combinational)
ex_pc_o  out  PC_W  registered PC
ex_aluop_o  out  8  registered ALU op (EXE_*_OP encodings from define.v)
ex_alusel_o  out  3  registered result select (EXE_RES_*)
ex_reg1_o  out  DATA_W  registered operand 1
ex_reg2_o  out  DATA_W  registered operand 2
ex_wd_o  out  REG_AW  registered destination
ex_wreg_o  out  1  registered write enable
ex_instvalid_o  out  1  registered: decode recognised the instruction

Behaviour:
- Decode: ORI/ANDI/XORI zero-extend imm16 (reg1=rs, operand2=imm, wd=rt); LUI gives operand2 = {imm16, zeros}, reg1 read disabled, operand1 = 0. SPECIAL AND/OR/XOR/NOR read rs, rt; wd = rd. SLL/SRL/SRA read rt into operand2 and operand1 = {zeros, sa = inst[10:6]}. Inst 0 = NOP: no write, instvalid=1. Unknown opcode/funct: NOP op, wreg=0, instvalid=0.
- Operand select, per port: read disabled -> imm (or sa); addr 0 -> 0 (never forwarded); FWD_EN and ex_wreg_i and ex_wd_i==addr and not ex_is_load_i -> ex_wdata_i; else FWD_EN and mem_wreg_i and mem_wd_i==addr -> mem_wdata_i; else regfile data. EX has priority over MEM.
- Hazard: stallreq_o=1 when inst_valid_i and an enabled read addr (non-zero) matches ex_wd_i with ex_wreg_i and ex_is_load_i. With FWD_EN=0, any enabled-read match on EX or MEM write also asserts it. Never asserted when inst_valid_i=0 or in reset.
- Register update, each rising clk, priority: rst -> all ex_* = 0 (aluop EXE_NOP_OP, alusel EXE_RES_NOP, wd 0, wreg 0, instvalid 0, pc 0); else flush_i -> same bubble; else stall_i -> hold; else stallreq_o or !inst_valid_i -> bubble; else load decoded values.
- Latency: one cycle from ID inputs to ex_* outputs.
- Simultaneous flush_i and stall_i: flush wins. Reset mid-stall clears the register; stallreq_o is 0 in reset.
- Widths: imm extension fills DATA_W-16 upper bits; DATA_W >= 32 required.

Test Plan:
- Reset: hold rst 2 cycles with ORI in ID -> all ex_* = 0, stallreq_o=0; release -> next edge ex_aluop_o=EXE_OR_OP.
- ori $1,$0,0x1100 -> after 1 clk ex_reg1_o=0, ex_reg2_o=0x00001100, ex_wd_o=1, ex_wreg_o=1; lui $2,0xABCD -> ex_reg2_o=0xABCD0000.
- Forwarding: or $3,$1,$2 with EX writing $1=0x5, MEM writing $1=0x7 and $2=0x9 -> ex_reg1_o=5, ex_reg2_o=9; FWD_EN=0 -> stallreq_o=1, bubble loaded.
- Load-use: ex_is_load_i=1, ex_wd_i=4, ID and $5,$4,$6 -> stallreq_o=1, ex_wreg_o=0 next edge; drop load -> instruction issues.
- Stall/flush: stall_i 3 cycles -> ex_* hold; flush_i+stall_i together -> bubble.
- sra $7,$8,3 with $8=0x80000000 -> ex_reg1_o=3, ex_reg2_o=0x80000000, alusel shift; unknown opcode 0x3F -> ex_instvalid_o=0, ex_wreg_o=0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage for logic/immediate/shift instructions with EX/MEM
// operand forwarding, load-use hazard detection and an integrated ID/EX register.
module id_stage_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              inst_valid_i,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    output logic              reg1_read_o,
    output logic              reg2_read_o,
    output logic [REG_AW-1:0] reg1_addr_o,
    output logic [REG_AW-1:0] reg2_addr_o,
    input  logic              ex_wreg_i,
    input  logic [REG_AW-1:0] ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [REG_AW-1:0] mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              stallreq_o,
    output logic [PC_W-1:0]   ex_pc_o,
    output logic [7:0]        ex_aluop_o,
    output logic [2:0]        ex_alusel_o,
    output logic [DATA_W-1:0] ex_reg1_o,
    output logic [DATA_W-1:0] ex_reg2_o,
    output logic [REG_AW-1:0] ex_wd_o,
    output logic              ex_wreg_o,
    output logic              ex_instvalid_o
);

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    logic [5:0]        op;
    logic [5:0]        fn;
    logic [4:0]        sa;
    logic [15:0]       imm16;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;

    assign op    = inst_i[31:26];
    assign fn    = inst_i[5:0];
    assign sa    = inst_i[10:6];
    assign imm16 = inst_i[15:0];
    assign rt    = inst_i[16 +: REG_AW];
    assign rd    = inst_i[11 +: REG_AW];

    logic [7:0]        dec_aluop;
    logic [2:0]        dec_alusel;
    logic [REG_AW-1:0] dec_wd;
    logic              dec_wreg;
    logic              dec_iv;
    logic [1:0]        rd_en;
    logic [DATA_W-1:0] imm_val [2];

    always_comb begin
        dec_aluop  = EXE_NOP_OP;
        dec_alusel = EXE_RES_NOP;
        dec_wd     = '0;
        dec_wreg   = 1'b0;
        dec_iv     = 1'b0;
        rd_en      = 2'b00;
        imm_val[0] = '0;
        imm_val[1] = '0;
        if (inst_i == '0) begin
            dec_iv = 1'b1;
        end else begin
            unique case (op)
                OP_SPECIAL: begin
                    unique case (fn)
                        FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                            rd_en      = 2'b11;
                            dec_wd     = rd;
                            dec_wreg   = 1'b1;
                            dec_iv     = 1'b1;
                            dec_alusel = EXE_RES_LOGIC;
                            unique case (fn)
                                FN_AND:  dec_aluop = EXE_AND_OP;
                                FN_OR:   dec_aluop = EXE_OR_OP;
                                FN_XOR:  dec_aluop = EXE_XOR_OP;
                                default: dec_aluop = EXE_NOR_OP;
                            endcase
                        end
                        FN_SLL, FN_SRL, FN_SRA: begin
                            // shift amount rides in operand 1, value to shift in operand 2
                            rd_en      = 2'b10;
                            imm_val[0] = {{(DATA_W-5){1'b0}}, sa};
                            dec_wd     = rd;
                            dec_wreg   = 1'b1;
                            dec_iv     = 1'b1;
                            dec_alusel = EXE_RES_SHIFT;
                            unique case (fn)
                                FN_SLL:  dec_aluop = EXE_SLL_OP;
                                FN_SRL:  dec_aluop = EXE_SRL_OP;
                                default: dec_aluop = EXE_SRA_OP;
                            endcase
                        end
                        default: ;
                    endcase
                end
                OP_ANDI, OP_ORI, OP_XORI: begin
                    rd_en      = 2'b01;
                    imm_val[1] = {{(DATA_W-16){1'b0}}, imm16};
                    dec_wd     = rt;
                    dec_wreg   = 1'b1;
                    dec_iv     = 1'b1;
                    dec_alusel = EXE_RES_LOGIC;
                    unique case (op)
                        OP_ANDI: dec_aluop = EXE_AND_OP;
                        OP_ORI:  dec_aluop = EXE_OR_OP;
                        default: dec_aluop = EXE_XOR_OP;
                    endcase
                end
                OP_LUI: begin
                    imm_val[1] = {imm16, {(DATA_W-16){1'b0}}};
                    dec_wd     = rt;
                    dec_wreg   = 1'b1;
                    dec_iv     = 1'b1;
                    dec_alusel = EXE_RES_LOGIC;
                    dec_aluop  = EXE_OR_OP;
                end
                default: ;
            endcase
        end
    end

    assign reg1_read_o = rd_en[0];
    assign reg2_read_o = rd_en[1];
    assign reg1_addr_o = inst_i[21 +: REG_AW];
    assign reg2_addr_o = inst_i[16 +: REG_AW];

    logic [REG_AW-1:0] rd_addr [2];
    logic [DATA_W-1:0] rf_data [2];
    logic [DATA_W-1:0] opnd    [2];
    logic [1:0]        ex_hit;
    logic [1:0]        mem_hit;

    assign rd_addr[0] = reg1_addr_o;
    assign rd_addr[1] = reg2_addr_o;
    assign rf_data[0] = reg1_data_i;
    assign rf_data[1] = reg2_data_i;

    always_comb begin
        ex_hit  = 2'b00;
        mem_hit = 2'b00;
        opnd[0] = '0;
        opnd[1] = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            ex_hit[p]  = rd_en[p] && (rd_addr[p] != '0) && ex_wreg_i && (ex_wd_i == rd_addr[p]);
            mem_hit[p] = rd_en[p] && (rd_addr[p] != '0) && mem_wreg_i && (mem_wd_i == rd_addr[p]);
            if (!rd_en[p])
                opnd[p] = imm_val[p];
            else if (rd_addr[p] == '0)
                opnd[p] = '0;
            else if ((FWD_EN != 0) && ex_hit[p] && !ex_is_load_i)
                opnd[p] = ex_wdata_i;
            else if ((FWD_EN != 0) && mem_hit[p])
                opnd[p] = mem_wdata_i;
            else
                opnd[p] = rf_data[p];
        end
    end

    // without forwarding every RAW hit must wait for the producer to retire
    assign stallreq_o = !rst && inst_valid_i &&
                        (((|ex_hit) && ex_is_load_i) || ((FWD_EN == 0) && (|(ex_hit | mem_hit))));

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            ex_pc_o        <= '0;
            ex_aluop_o     <= EXE_NOP_OP;
            ex_alusel_o    <= EXE_RES_NOP;
            ex_reg1_o      <= '0;
            ex_reg2_o      <= '0;
            ex_wd_o        <= '0;
            ex_wreg_o      <= 1'b0;
            ex_instvalid_o <= 1'b0;
        end else if (!stall_i) begin
            if (stallreq_o || !inst_valid_i) begin
                ex_pc_o        <= '0;
                ex_aluop_o     <= EXE_NOP_OP;
                ex_alusel_o    <= EXE_RES_NOP;
                ex_reg1_o      <= '0;
                ex_reg2_o      <= '0;
                ex_wd_o        <= '0;
                ex_wreg_o      <= 1'b0;
                ex_instvalid_o <= 1'b0;
            end else begin
                ex_pc_o        <= pc_i;
                ex_aluop_o     <= dec_aluop;
                ex_alusel_o    <= dec_alusel;
                ex_reg1_o      <= opnd[0];
                ex_reg2_o      <= opnd[1];
                ex_wd_o        <= dec_wd;
                ex_wreg_o      <= dec_wreg;
                ex_instvalid_o <= dec_iv;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomised and directed checks of id_stage_pipe (forwarding on and off)
// against a rule-level reference model of decode, operand select and hazards.
module tb_id_stage_pipe;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic        iv;
    } ex_t;

    typedef struct packed {
        logic stall;
        logic r1en;
        logic r2en;
        ex_t  ex;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst, inst_valid, ex_wreg, ex_load, mem_wreg, stall, flush;
    logic [31:0] pc, inst, reg1_data, reg2_data, ex_wdata, mem_wdata;
    logic [4:0]  ex_wd, mem_wd;

    logic        f_r1rd, f_r2rd, f_stallreq, n_r1rd, n_r2rd, n_stallreq;
    logic [4:0]  f_r1a, f_r2a, n_r1a, n_r2a;
    logic [31:0] f_pc, f_r1, f_r2, n_pc, n_r1, n_r2;
    logic [7:0]  f_aluop, n_aluop;
    logic [2:0]  f_alusel, n_alusel;
    logic [4:0]  f_wd, n_wd;
    logic        f_wreg, f_iv, n_wreg, n_iv;

    ex_t got_f, got_n, mdl_f, mdl_n;
    assign got_f = {f_pc, f_aluop, f_alusel, f_r1, f_r2, f_wd, f_wreg, f_iv};
    assign got_n = {n_pc, n_aluop, n_alusel, n_r1, n_r2, n_wd, n_wreg, n_iv};

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .INST_W(32), .PC_W(32), .REG_AW(5), .FWD_EN(1)) u_dut (
        .clk(clk), .rst(rst), .pc_i(pc), .inst_i(inst), .inst_valid_i(inst_valid),
        .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
        .reg1_read_o(f_r1rd), .reg2_read_o(f_r2rd), .reg1_addr_o(f_r1a), .reg2_addr_o(f_r2a),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_load),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
        .stall_i(stall), .flush_i(flush), .stallreq_o(f_stallreq),
        .ex_pc_o(f_pc), .ex_aluop_o(f_aluop), .ex_alusel_o(f_alusel), .ex_reg1_o(f_r1),
        .ex_reg2_o(f_r2), .ex_wd_o(f_wd), .ex_wreg_o(f_wreg), .ex_instvalid_o(f_iv));

    id_stage_pipe #(.DATA_W(32), .INST_W(32), .PC_W(32), .REG_AW(5), .FWD_EN(0)) u_dut_nf (
        .clk(clk), .rst(rst), .pc_i(pc), .inst_i(inst), .inst_valid_i(inst_valid),
        .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
        .reg1_read_o(n_r1rd), .reg2_read_o(n_r2rd), .reg1_addr_o(n_r1a), .reg2_addr_o(n_r2a),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_load),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
        .stall_i(stall), .flush_i(flush), .stallreq_o(n_stallreq),
        .ex_pc_o(n_pc), .ex_aluop_o(n_aluop), .ex_alusel_o(n_alusel), .ex_reg1_o(n_r1),
        .ex_reg2_o(n_r2), .ex_wd_o(n_wd), .ex_wreg_o(n_wreg), .ex_instvalid_o(n_iv));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic check_ex(input string tag, input ex_t g, input ex_t e);
        chk({tag, ".pc"},     64'(g.pc),     64'(e.pc));
        chk({tag, ".aluop"},  64'(g.aluop),  64'(e.aluop));
        chk({tag, ".alusel"}, 64'(g.alusel), 64'(e.alusel));
        chk({tag, ".reg1"},   64'(g.r1),     64'(e.r1));
        chk({tag, ".reg2"},   64'(g.r2),     64'(e.r2));
        chk({tag, ".wd"},     64'(g.wd),     64'(e.wd));
        chk({tag, ".wreg"},   64'(g.wreg),   64'(e.wreg));
        chk({tag, ".iv"},     64'(g.iv),     64'(e.iv));
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    // value an operand port would deliver under the forwarding rules
    function automatic logic [31:0] fetch(input logic en, input logic [4:0] a,
                                          input logic [31:0] imm, rf, input bit fwd);
        if (!en) return imm;
        if (a == 0) return 32'h0;
        if (fwd && ex_wreg && ex_wd == a && !ex_load) return ex_wdata;
        if (fwd && mem_wreg && mem_wd == a) return mem_wdata;
        return rf;
    endfunction

    function automatic logic hazard(input logic en, input logic [4:0] a, input bit fwd);
        if (!en || a == 0) return 1'b0;
        if (ex_wreg && ex_wd == a && (ex_load || !fwd)) return 1'b1;
        return !fwd && mem_wreg && mem_wd == a;
    endfunction

    function automatic dec_t model_dec(input bit fwd);
        dec_t d;
        logic [5:0] op, fn;
        logic [31:0] i1, i2;
        op = inst[31:26];
        fn = inst[5:0];
        d  = '0;
        i1 = 32'h0;
        i2 = 32'h0;
        if (inst == 32'h0) begin
            d.ex.iv = 1'b1;
        end else if (op == 6'h0c || op == 6'h0d || op == 6'h0e) begin
            d.r1en = 1'b1;
            i2 = {16'h0, inst[15:0]};
            d.ex.aluop = (op == 6'h0c) ? 8'h24 : (op == 6'h0d) ? 8'h25 : 8'h26;
            d.ex.alusel = 3'd1; d.ex.wd = inst[20:16]; d.ex.wreg = 1'b1; d.ex.iv = 1'b1;
        end else if (op == 6'h0f) begin
            i2 = {inst[15:0], 16'h0};
            d.ex.aluop = 8'h25;
            d.ex.alusel = 3'd1; d.ex.wd = inst[20:16]; d.ex.wreg = 1'b1; d.ex.iv = 1'b1;
        end else if (op == 6'h00 && fn >= 6'h24 && fn <= 6'h27) begin
            d.r1en = 1'b1; d.r2en = 1'b1;
            d.ex.aluop = {2'b00, fn};
            d.ex.alusel = 3'd1; d.ex.wd = inst[15:11]; d.ex.wreg = 1'b1; d.ex.iv = 1'b1;
        end else if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
            d.r2en = 1'b1;
            i1 = {27'h0, inst[10:6]};
            d.ex.aluop = (fn == 6'h00) ? 8'h7c : {2'b00, fn};
            d.ex.alusel = 3'd2; d.ex.wd = inst[15:11]; d.ex.wreg = 1'b1; d.ex.iv = 1'b1;
        end
        d.ex.pc = pc;
        d.ex.r1 = fetch(d.r1en, inst[25:21], i1, reg1_data, fwd);
        d.ex.r2 = fetch(d.r2en, inst[20:16], i2, reg2_data, fwd);
        d.stall = !rst && inst_valid &&
                  (hazard(d.r1en, inst[25:21], fwd) || hazard(d.r2en, inst[20:16], fwd));
        return d;
    endfunction

    function automatic ex_t next_state(input ex_t cur, input dec_t d);
        if (rst || flush) return '0;
        if (stall) return cur;
        if (d.stall || !inst_valid) return '0;
        return d.ex;
    endfunction

    // inputs are already driven; check combinational outputs, clock, check register
    task automatic cycle();
        dec_t df, dn;
        #1;
        df = model_dec(1'b1);
        dn = model_dec(1'b0);
        chk("stallreq_fwd",  64'(f_stallreq), 64'(df.stall));
        chk("stallreq_nfwd", 64'(n_stallreq), 64'(dn.stall));
        chk("reg_read", 64'({f_r1rd, f_r2rd, n_r1rd, n_r2rd}), 64'({df.r1en, df.r2en, dn.r1en, dn.r2en}));
        chk("reg_addr", 64'({f_r1a, f_r2a}), 64'({inst[25:21], inst[20:16]}));
        @(posedge clk);
        mdl_f = next_state(mdl_f, df);
        mdl_n = next_state(mdl_n, dn);
        #1;
        check_ex("fwd", got_f, mdl_f);
        check_ex("nfwd", got_n, mdl_n);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; inst_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        ex_wreg = 1'b0; ex_load = 1'b0; ex_wd = 5'd0; ex_wdata = 32'h0;
        mem_wreg = 1'b0; mem_wd = 5'd0; mem_wdata = 32'h0;
        reg1_data = 32'h0; reg2_data = 32'h0;
    endtask

    initial begin
        mdl_f = '0;
        mdl_n = '0;
        idle_inputs();
        pc   = 32'h0000_1000;
        inst = itype(6'h0d, 5'd0, 5'd1, 16'h1100);

        // reset held two cycles with ORI waiting in ID
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_stallreq", 64'(f_stallreq), 64'd0);
        chk("reset_aluop",    64'(f_aluop),    64'd0);
        rst = 1'b0;
        cycle();
        chk("ori_aluop", 64'(f_aluop), 64'h25);
        chk("ori_reg1",  64'(f_r1),    64'h0);
        chk("ori_reg2",  64'(f_r2),    64'h0000_1100);
        chk("ori_wd",    64'(f_wd),    64'd1);

        pc = 32'h0000_1004; inst = itype(6'h0f, 5'd0, 5'd2, 16'hABCD);
        cycle();
        chk("lui_reg2", 64'(f_r2), 64'hABCD_0000);

        // EX writes $1, MEM writes $2; EX beats MEM
        pc = 32'h0000_1008; inst = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h25);
        ex_wreg = 1'b1; ex_wd = 5'd1; ex_wdata = 32'h5;
        mem_wreg = 1'b1; mem_wd = 5'd2; mem_wdata = 32'h9;
        reg1_data = 32'hDEAD_0001; reg2_data = 32'hDEAD_0002;
        cycle();
        chk("fwd_reg1", 64'(f_r1), 64'h5);
        chk("fwd_reg2", 64'(f_r2), 64'h9);
        chk("nfwd_bubble_wreg", 64'(n_wreg), 64'd0);
        mem_wd = 5'd1; mem_wdata = 32'h7;
        cycle();
        chk("fwd_ex_over_mem", 64'(f_r1), 64'h5);

        // load-use on $4
        idle_inputs();
        pc = 32'h0000_100c; inst = rtype(5'd4, 5'd6, 5'd5, 5'd0, 6'h24);
        ex_wreg = 1'b1; ex_load = 1'b1; ex_wd = 5'd4; ex_wdata = 32'h44;
        #1;
        chk("loaduse_stallreq", 64'(f_stallreq), 64'd1);
        cycle();
        chk("loaduse_wreg", 64'(f_wreg), 64'd0);
        ex_load = 1'b0;
        cycle();
        chk("loaduse_issue", 64'({f_wreg, f_wd}), 64'({1'b1, 5'd5}));

        // hold for three cycles, then flush together with stall
        idle_inputs();
        pc = 32'h0000_1010; inst = itype(6'h0e, 5'd3, 5'd9, 16'h00F0); reg1_data = 32'h0F0F;
        cycle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst = itype(6'h0c, 5'd2, 5'd10, 16'(i));
            pc   = pc + 4;
            cycle();
            chk("stall_hold_wd", 64'(f_wd), 64'd9);
        end
        flush = 1'b1;
        cycle();
        chk("flush_stall_iv", 64'(f_iv), 64'd0);

        idle_inputs();
        pc = 32'h0000_1020; inst = rtype(5'd0, 5'd8, 5'd7, 5'd3, 6'h03); reg2_data = 32'h8000_0000;
        cycle();
        chk("sra_reg1",   64'(f_r1),     64'd3);
        chk("sra_reg2",   64'(f_r2),     64'h8000_0000);
        chk("sra_alusel", 64'(f_alusel), 64'd2);
        inst = itype(6'h3f, 5'd1, 5'd2, 16'h1234);
        cycle();
        chk("unknown_iv_wreg", 64'({f_iv, f_wreg}), 64'd0);

        for (int n = 0; n < 400; n++) begin
            int unsigned k;
            logic [4:0] rs, rt, rd;
            k  = $urandom_range(0, 12);
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            case (k)
                0, 1, 2, 3: inst = itype(6'h0c + 6'(k), rs, rt, 16'($urandom));
                4, 5, 6, 7: inst = rtype(rs, rt, rd, 5'd0, 6'h24 + 6'(k - 4));
                8:  inst = rtype(5'd0, rt, rd, 5'($urandom), 6'h00);
                9:  inst = rtype(5'd0, rt, rd, 5'($urandom), 6'h02);
                10: inst = rtype(5'd0, rt, rd, 5'($urandom), 6'h03);
                11: inst = 32'h0;
                default: inst = ($urandom_range(0, 1) == 0) ? itype(6'h3f, rs, rt, 16'($urandom))
                                                              : rtype(rs, rt, rd, 5'd0, 6'h3f);
            endcase
            pc         = $urandom;
            rst        = ($urandom_range(0, 39) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            stall      = ($urandom_range(0, 5) == 0);
            inst_valid = ($urandom_range(0, 7) != 0);
            ex_wreg    = $urandom_range(0, 1) == 1;
            ex_load    = ($urandom_range(0, 3) == 0);
            ex_wd      = 5'($urandom_range(0, 7));
            ex_wdata   = $urandom;
            mem_wreg   = $urandom_range(0, 1) == 1;
            mem_wd     = 5'($urandom_range(0, 7));
            mem_wdata  = $urandom;
            reg1_data  = $urandom;
            reg2_data  = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
